vga_pixel_stage: RTL and testbench

Pixel-generation stage directly downstream of the VGA timing generator. It takes the raw pixel position, active flag and syncs, maps each pixel to a 20×15 grid of 32×32-px tiles, and queries the game's body-occupancy store one tile at a time. It emits registered 2-bit-per-channel RGB with syncs delayed to match. It also produces the per-frame and per-game-step tick pulses that pace the snake game logic.

---
 rtl/vga_pixel_stage.sv | 128 ++++++++++++
 tb/tb_vga_pixel_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_pixel_stage.sv
// Pixel-generation stage behind the VGA timing generator: maps pixels to tiles,
// queries the body store, colours each tile and paces the game with frame/step ticks.
module vga_pixel_stage #(
   parameter int BIT        = 10,
   parameter int HRES       = 640,
   parameter int VRES       = 480,
   parameter int TILE_SHIFT = 5,
   parameter int GRID_W     = 20,
   parameter int GRID_H     = 15,
   parameter int TICK_DIV   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [BIT-1:0] x_pos,
   input  logic [BIT-1:0] y_pos,
   input  logic           active,
   input  logic           h_sync,
   input  logic           v_sync,
   input  logic [4:0]     head_x,
   input  logic [3:0]     head_y,
   input  logic [4:0]     food_x,
   input  logic [3:0]     food_y,
   input  logic           game_over,
   output logic [4:0]     query_x,
   output logic [3:0]     query_y,
   input  logic           body_hit,
   output logic [1:0]     r,
   output logic [1:0]     g,
   output logic [1:0]     b,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic           frame_tick,
   output logic           game_tick
);
   localparam int FCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic           w_act;
   logic           w_frame;
   logic [4:0]     r_tx;
   logic [3:0]     r_ty;
   logic           r_act;
   logic           r_hs;
   logic           r_vs;
   logic           r_go;
   logic           r_frame;
   logic [5:0]     w_rgb;
   logic [5:0]     r_rgb;
   logic           r_hso;
   logic           r_vso;
   logic           r_ft;
   logic           r_gt;
   logic [FCW-1:0] r_fc;

   // Range qualification keeps tile indices meaningful even if active is ever misaligned.
   assign w_act   = active && (x_pos < BIT'(HRES)) && (y_pos < BIT'(VRES));
   assign w_frame = (x_pos == '0) && (y_pos == BIT'(VRES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx    <= '0;
         r_ty    <= '0;
         r_act   <= 1'b0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_go    <= 1'b0;
         r_frame <= 1'b0;
      end else begin
         r_act   <= w_act;
         r_tx    <= w_act ? x_pos[TILE_SHIFT+4:TILE_SHIFT] : 5'd0;
         r_ty    <= w_act ? y_pos[TILE_SHIFT+3:TILE_SHIFT] : 4'd0;
         r_hs    <= h_sync;
         r_vs    <= v_sync;
         r_go    <= game_over;
         r_frame <= w_frame;
      end
   end

   assign query_x = r_tx;
   assign query_y = r_ty;

   always_comb begin
      w_rgb = 6'b00_00_00;
      if (!r_act) begin
         w_rgb = 6'b00_00_00;
      end else if ((r_tx == 5'd0) || (r_tx == 5'(GRID_W - 1)) ||
                   (r_ty == 4'd0) || (r_ty == 4'(GRID_H - 1))) begin
         w_rgb = 6'b01_01_01;
      end else if ((r_tx == head_x) && (r_ty == head_y)) begin
         w_rgb = 6'b00_11_00;
      end else if (body_hit) begin
         w_rgb = 6'b00_10_00;
      end else if ((r_tx == food_x) && (r_ty == food_y)) begin
         w_rgb = 6'b11_00_00;
      end else if (r_go) begin
         w_rgb = 6'b01_00_00;
      end else begin
         w_rgb = 6'b00_00_01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rgb <= '0;
         r_hso <= 1'b1;
         r_vso <= 1'b1;
         r_ft  <= 1'b0;
         r_gt  <= 1'b0;
         r_fc  <= '0;
      end else begin
         r_rgb <= w_rgb;
         r_hso <= r_hs;
         r_vso <= r_vs;
         r_ft  <= r_frame;
         r_gt  <= r_frame && (r_fc == FCW'(TICK_DIV - 1));
         if (r_frame) begin
            r_fc <= (r_fc == FCW'(TICK_DIV - 1)) ? '0 : r_fc + 1'b1;
         end
      end
   end

   assign r          = r_rgb[5:4];
   assign g          = r_rgb[3:2];
   assign b          = r_rgb[1:0];
   assign hsync_o    = r_hso;
   assign vsync_o    = r_vso;
   assign frame_tick = r_ft;
   assign game_tick  = r_gt;
endmodule

// File: tb/tb_vga_pixel_stage.sv
// Directed bench for vga_pixel_stage: reset, latency, colour priority, border/query and ticks.
module tb_vga_pixel_stage;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] x_pos = '0;
   logic [9:0] y_pos = '0;
   logic       active = 1'b0;
   logic       h_sync = 1'b1;
   logic       v_sync = 1'b1;
   logic [4:0] head_x = 5'd10;
   logic [3:0] head_y = 4'd10;
   logic [4:0] food_x = 5'd12;
   logic [3:0] food_y = 4'd12;
   logic       game_over = 1'b0;
   logic [4:0] query_x;
   logic [3:0] query_y;
   logic       body_hit;
   logic [1:0] r, g, b;
   logic       hsync_o, vsync_o, frame_tick, game_tick;

   logic       body_en = 1'b0;
   logic [4:0] body_x = 5'd5;
   logic [3:0] body_y = 4'd5;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   // Single-segment body store model answering the current query combinationally.
   assign body_hit = body_en && (query_x == body_x) && (query_y == body_y);

   vga_pixel_stage dut (
      .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .active(active),
      .h_sync(h_sync), .v_sync(v_sync), .head_x(head_x), .head_y(head_y),
      .food_x(food_x), .food_y(food_y), .game_over(game_over),
      .query_x(query_x), .query_y(query_y), .body_hit(body_hit),
      .r(r), .g(g), .b(b), .hsync_o(hsync_o), .vsync_o(vsync_o),
      .frame_tick(frame_tick), .game_tick(game_tick)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      nvec++;
      assert (obs === exp_v) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one pixel, check the query after the first edge and colour after the second.
   task automatic pix(input string tag, input int x, input int y, input logic act,
                      input logic [4:0] eqx, input logic [3:0] eqy, input logic [5:0] ergb);
      x_pos = 10'(x); y_pos = 10'(y); active = act; h_sync = 1'b1; v_sync = 1'b1;
      tick();
      chk({tag, "_query"}, {7'd0, query_x, query_y}, {7'd0, eqx, eqy});
      tick();
      chk({tag, "_rgb"}, {10'd0, r, g, b}, {10'd0, ergb});
   endtask

   initial begin
      logic prev_hs;
      logic prev_fs;
      int   frames;
      int   ft_count;
      // Reset held while driving an active pixel
      x_pos = 10'd100; y_pos = 10'd100; active = 1'b1;
      repeat (3) tick();
      chk("rst_rgb", {10'd0, r, g, b}, 16'h0);
      chk("rst_syncs", {14'd0, hsync_o, vsync_o}, 16'h3);
      chk("rst_ticks", {14'd0, frame_tick, game_tick}, 16'h0);
      chk("rst_query", {7'd0, query_x, query_y}, 16'h0);

      // Release: colour appears exactly after the second edge
      rst_n = 1'b1;
      tick();
      chk("rel_edge1_rgb", {10'd0, r, g, b}, 16'h0);
      chk("rel_edge1_query", {7'd0, query_x, query_y}, {7'd0, 5'd3, 4'd3});
      tick();
      chk("rel_edge2_rgb", {10'd0, r, g, b}, 16'h01);

      pix("plain_100", 100, 100, 1'b1, 5'd3, 4'd3, 6'b00_00_01);

      // Priority on tile (5,5)
      head_x = 5'd5; head_y = 4'd5; food_x = 5'd5; food_y = 4'd5; body_en = 1'b1;
      pix("prio_head", 170, 170, 1'b1, 5'd5, 4'd5, 6'b00_11_00);
      head_x = 5'd7; head_y = 4'd7;
      pix("prio_body", 170, 170, 1'b1, 5'd5, 4'd5, 6'b00_10_00);
      body_en = 1'b0;
      pix("prio_food", 170, 170, 1'b1, 5'd5, 4'd5, 6'b11_00_00);

      // Border tiles and blanking
      pix("border_left", 0, 200, 1'b1, 5'd0, 4'd6, 6'b01_01_01);
      pix("border_corner", 639, 479, 1'b1, 5'd19, 4'd14, 6'b01_01_01);
      pix("border_top", 320, 31, 1'b1, 5'd10, 4'd0, 6'b01_01_01);
      pix("inner_edge", 608, 447, 1'b1, 5'd19, 4'd13, 6'b01_01_01);
      pix("inner_ok", 607, 447, 1'b1, 5'd18, 4'd13, 6'b00_00_01);
      body_en = 1'b1; head_x = 5'd5; head_y = 4'd5;
      pix("blank", 170, 170, 1'b0, 5'd0, 4'd0, 6'b00_00_00);
      body_en = 1'b0;

      // Game over background; head still green
      game_over = 1'b1; head_x = 5'd7; head_y = 4'd7;
      pix("go_plain", 100, 100, 1'b1, 5'd3, 4'd3, 6'b01_00_00);
      head_x = 5'd3; head_y = 4'd3;
      pix("go_head", 100, 100, 1'b1, 5'd3, 4'd3, 6'b00_11_00);
      game_over = 1'b0;

      // Horizontal sync pulse across x = 656..751, seen one edge after stage 1
      active = 1'b0; y_pos = 10'd490; v_sync = 1'b1;
      prev_hs = 1'b1;
      for (int x = 654; x <= 754; x++) begin
         x_pos = 10'(x);
         h_sync = !((x >= 656) && (x <= 751));
         tick();
         chk($sformatf("hsync_x%0d", x - 1), {15'd0, hsync_o}, {15'd0, prev_hs});
         chk($sformatf("vsync_x%0d", x - 1), {15'd0, vsync_o}, 16'h1);
         prev_hs = h_sync;
      end
      h_sync = 1'b1;

      // Fresh reset, then 17 frame starts with idle cycles between
      rst_n = 1'b0;
      tick();
      chk("rst2_ticks", {14'd0, frame_tick, game_tick}, 16'h0);
      rst_n = 1'b1;
      prev_fs = 1'b0; frames = 0; ft_count = 0;
      for (int f = 1; f <= 17; f++) begin
         for (int c = 0; c < 4; c++) begin
            x_pos = (c == 0) ? 10'd0 : 10'(c);
            y_pos = 10'd480;
            tick();
            if (frame_tick) ft_count++;
            chk($sformatf("frame_tick_f%0d_c%0d", f, c), {15'd0, frame_tick}, {15'd0, prev_fs});
            chk($sformatf("game_tick_f%0d_c%0d", f, c), {15'd0, game_tick},
                {15'd0, prev_fs && ((frames % 8) == 0)});
            prev_fs = (c == 0);
            if (c == 0) frames++;
         end
      end
      y_pos = 10'd0;
      tick();
      if (frame_tick) ft_count++;
      chk("frame_tick_last", {15'd0, frame_tick}, {15'd0, prev_fs});
      chk("frame_tick_count", 16'(ft_count), 16'd17);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
